// File: rtl/bullet2_palette_encoder.sv
// Maps an RGB pixel to the nearest entry of a fixed 16-colour palette by L1 distance,
// scanning one candidate per cycle with a valid/ready handshake on both sides.
module bullet2_palette_encoder #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [23:0] i_rgb,
  input  logic        i_opaque,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_index,
  output logic [9:0]  o_dist
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  best_idx_q, best_idx_d;
  logic [9:0]  best_dist_q, best_dist_d;
  logic [23:0] rgb_q, rgb_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  dist_q, dist_d;

  logic [9:0]  cand_dist;
  logic        better;

  function automatic logic [23:0] palette(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'd0:    c = 24'h000000;
      4'd1:    c = 24'hfefe00;
      4'd2:    c = 24'hffa600;
      4'd3:    c = 24'hf1a60d;
      4'd4:    c = 24'hf2930e;
      4'd5:    c = 24'hea8c0a;
      4'd6:    c = 24'hf1870d;
      4'd7:    c = 24'hff7f00;
      4'd8:    c = 24'hf1830d;
      4'd9:    c = 24'hf17c0d;
      4'd10:   c = 24'hf1720d;
      4'd11:   c = 24'hf1660d;
      4'd12:   c = 24'hf2590c;
      4'd13:   c = 24'hf04b0d;
      4'd14:   c = 24'h925a00;
      default: c = 24'hfd0000;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] l1(input logic [23:0] a, input logic [23:0] b);
    return {2'b00, absdiff(a[23:16], b[23:16])} + {2'b00, absdiff(a[15:8], b[15:8])}
         + {2'b00, absdiff(a[7:0], b[7:0])};
  endfunction

  assign cand_dist = l1(rgb_q, palette(k_q));
  assign better    = cand_dist < best_dist_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    rgb_d       = rgb_q;
    idx_d       = idx_q;
    dist_d      = dist_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          rgb_d = i_rgb;
          if (!i_opaque) begin
            idx_d   = 4'd0;
            dist_d  = 10'd0;
            state_d = StDone;
          end else begin
            k_d         = 4'd1;
            best_idx_d  = 4'd0;
            best_dist_d = 10'h3ff;
            state_d     = StSearch;
          end
        end
      end
      StSearch: begin
        if (better) begin
          best_idx_d  = k_q;
          best_dist_d = cand_dist;
        end
        if (k_q == 4'd15 || (EARLY_EXIT && cand_dist == 10'd0)) begin
          // Publish the result including this cycle's candidate; k stays put.
          idx_d   = better ? k_q : best_idx_q;
          dist_d  = better ? cand_dist : best_dist_q;
          state_d = StDone;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      k_q         <= 4'd1;
      best_idx_q  <= 4'd0;
      best_dist_q <= 10'h3ff;
      rgb_q       <= 24'd0;
      idx_q       <= 4'd0;
      dist_q      <= 10'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      rgb_q       <= rgb_d;
      idx_q       <= idx_d;
      dist_q      <= dist_d;
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StDone);
  assign o_index = idx_q;
  assign o_dist  = dist_q;

endmodule

// File: tb/tb_bullet2_palette_encoder.sv
// Directed bench for bullet2_palette_encoder: one instance per EARLY_EXIT setting,
// hand-computed nearest-colour results, latencies, backpressure and reset abort.
module tb_bullet2_palette_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] rgb = 24'd0;
  logic        opaque = 1'b0;
  logic        ready = 1'b0;

  logic        ordy0, ordy1, ov0, ov1;
  logic [3:0]  oidx0, oidx1;
  logic [9:0]  odist0, odist1;

  logic        ordy, ov;
  logic [3:0]  oidx;
  logic [9:0]  odist;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bullet2_palette_encoder #(.EARLY_EXIT(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid & ~sel), .o_ready(ordy0),
    .i_rgb(rgb), .i_opaque(opaque), .o_valid(ov0), .i_ready(ready),
    .o_index(oidx0), .o_dist(odist0)
  );

  bullet2_palette_encoder #(.EARLY_EXIT(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid & sel), .o_ready(ordy1),
    .i_rgb(rgb), .i_opaque(opaque), .o_valid(ov1), .i_ready(ready),
    .o_index(oidx1), .o_dist(odist1)
  );

  assign ordy  = sel ? ordy1 : ordy0;
  assign ov    = sel ? ov1 : ov0;
  assign oidx  = sel ? oidx1 : oidx0;
  assign odist = sel ? odist1 : odist0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one pixel and wait for the result; lat counts cycles from acceptance.
  task automatic send(input logic [23:0] c, input logic op, output int lat);
    @(negedge clk);
    rgb    = c;
    opaque = op;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the block must ignore them.
    rgb    = ~c;
    opaque = ~op;
    lat    = 1;
    while (!ov && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [23:0] c, input logic op,
                     input int exp_lat, input logic [3:0] exp_idx, input logic [9:0] exp_dist);
    int lat;
    send(c, op, lat);
    check_eq({tag, " valid"}, 32'(ov), 32'd1);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " index"}, 32'(oidx), 32'(exp_idx));
    check_eq({tag, " dist"}, 32'(odist), 32'(exp_dist));
    check_eq({tag, " ready in done"}, 32'(ordy), 32'd0);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check_eq({tag, " back to idle"}, 32'(ordy), 32'd1);
    check_eq({tag, " valid drops"}, 32'(ov), 32'd0);
    check_eq({tag, " index held"}, 32'(oidx), 32'(exp_idx));
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset ready", 32'(ordy0), 32'd1);
    check_eq("reset valid", 32'(ov0), 32'd0);
    check_eq("reset index", 32'(oidx0), 32'd0);
    check_eq("reset dist", 32'(odist0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    sel = 1'b0;
    run("exact fefe00", 24'hfefe00, 1'b1, 16, 4'd1, 10'd0);
    run("black", 24'h000000, 1'b1, 16, 4'd14, 10'd236);
    run("exact ff7f00", 24'hff7f00, 1'b1, 16, 4'd7, 10'd0);
    run("tie f1850d", 24'hf1850d, 1'b1, 16, 4'd6, 10'd2);
    run("transparent", 24'h123456, 1'b0, 1, 4'd0, 10'd0);
    run("red near fd", 24'hf00000, 1'b1, 16, 4'd15, 10'd13);

    sel = 1'b1;
    run("ee ff7f00", 24'hff7f00, 1'b1, 8, 4'd7, 10'd0);
    run("ee fefe00", 24'hfefe00, 1'b1, 2, 4'd1, 10'd0);
    run("ee no exact", 24'hf1850d, 1'b1, 16, 4'd6, 10'd2);
    sel = 1'b0;

    // Backpressure: result must sit still while i_ready is low.
    send(24'hf1850d, 1'b1, lat);
    check_eq("bp latency", 32'(lat), 32'd16);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp valid", 32'(ov), 32'd1);
      check_eq("bp index", 32'(oidx), 32'd6);
      check_eq("bp dist", 32'(odist), 32'd2);
      check_eq("bp ready", 32'(ordy), 32'd0);
    end
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check_eq("bp release ready", 32'(ordy), 32'd1);
    check_eq("bp release valid", 32'(ov), 32'd0);

    // Reset during a search: abort and discard.
    @(negedge clk);
    rgb    = 24'hff7f00;
    opaque = 1'b1;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid search busy", 32'(ordy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort valid", 32'(ov), 32'd0);
    check_eq("abort index", 32'(oidx), 32'd0);
    check_eq("abort dist", 32'(odist), 32'd0);
    check_eq("abort ready", 32'(ordy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_eq("no stale result", 32'(ov), 32'd0);
    end
    run("post reset fefe00", 24'hfefe00, 1'b1, 16, 4'd1, 10'd0);

    // Reset while a result is held under backpressure.
    send(24'h000000, 1'b1, lat);
    check_eq("held before reset", 32'(oidx), 32'd14);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("done reset valid", 32'(ov), 32'd0);
    check_eq("done reset index", 32'(oidx), 32'd0);
    check_eq("done reset dist", 32'(odist), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
